// File: rtl/my_arith_pkg.sv
// Shared arithmetic definitions: default operand width, the serial-unit FSM
// state type and the helper that sizes the bit counter.
package my_arith_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/my_fulladder.sv
// One-bit full adder; the serial subtractor feeds it a, ~b and the carry FF.
module my_fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/my_serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock, valid/ready handshake on both sides.
// Optional zero/neg/ovf flag outputs are enabled by defining MY_SERIAL_SUBTRACTOR_FLAGS_EN.
module my_serial_subtractor
  import my_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef MY_SERIAL_SUBTRACTOR_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] diff_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             borrow_reg;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  my_fulladder u_fa (
    .a    (a_sh[0]),
    .b    (~b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 lands at diff[0].
  assign diff_next = {fa_sum, diff_reg[WIDTH-1:1]};
  assign last_bit  = (state == RUN) && (cnt == LAST_BIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      diff_reg   <= '0;
      cnt        <= '0;
      carry      <= 1'b1;
      borrow_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            cnt   <= '0;
            carry <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          diff_reg <= diff_next;
          carry    <= fa_cout;
          if (cnt == LAST_BIT) begin
            borrow_reg <= ~fa_cout;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_reg;
  assign borrow    = borrow_reg;

`ifdef MY_SERIAL_SUBTRACTOR_FLAGS_EN
  // Operand signs are shifted out during RUN, so keep them for the overflow test.
  logic sign_a;
  logic sign_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        sign_a <= a[WIDTH-1];
        sign_b <= b[WIDTH-1];
      end
      if (last_bit) begin
        zero <= (diff_next == '0);
        neg  <= fa_sum;
        ovf  <= (sign_a ^ sign_b) & (fa_sum ^ sign_a);
      end
    end
  end
`endif

endmodule

// File: tb/tb_my_serial_subtractor.sv
// Directed self-checking bench for my_serial_subtractor (WIDTH=16); flag checks
// are compiled in when MY_SERIAL_SUBTRACTOR_FLAGS_EN is defined.
module tb_my_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef MY_SERIAL_SUBTRACTOR_FLAGS_EN
  logic         zero;
  logic         neg;
  logic         ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  my_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef MY_SERIAL_SUBTRACTOR_FLAGS_EN
    ,
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Present one operand pair, scramble the ports after acceptance, and count
  // edges from the accept edge until out_valid rises (-1 on timeout).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~av;
    b = bv ^ 16'h5A5A;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (diff !== 16'h0000) begin miscompares++; $display("FAIL reset_diff got=%h exp=0000", diff); end
    vectors++; if (borrow !== 1'b0) begin miscompares++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
`ifdef MY_SERIAL_SUBTRACTOR_FLAGS_EN
    vectors++; if ({zero, neg, ovf} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got=%b exp=000", {zero, neg, ovf}); end
`endif
    @(negedge clk);
    reset = 1'b0;
    $display("reset: in_ready=%b out_valid=%b diff=%h borrow=%b", in_ready, out_valid, diff, borrow);
  endtask

  task automatic test_vectors();
    logic [W-1:0] ta [8];
    logic [W-1:0] tb_ [8];
    logic [W-1:0] td [8];
    logic         tbr [8];
`ifdef MY_SERIAL_SUBTRACTOR_FLAGS_EN
    logic [2:0]   tf [8];  // {zero, neg, ovf}
`endif
    int lat;
    ta[0] = 16'h0005; tb_[0] = 16'h0003; td[0] = 16'h0002; tbr[0] = 1'b0;
    ta[1] = 16'h0003; tb_[1] = 16'h0005; td[1] = 16'hFFFE; tbr[1] = 1'b1;
    ta[2] = 16'h8000; tb_[2] = 16'h0001; td[2] = 16'h7FFF; tbr[2] = 1'b0;
    ta[3] = 16'h0000; tb_[3] = 16'h0000; td[3] = 16'h0000; tbr[3] = 1'b0;
    ta[4] = 16'hFFFF; tb_[4] = 16'hFFFF; td[4] = 16'h0000; tbr[4] = 1'b0;
    ta[5] = 16'h0000; tb_[5] = 16'h0001; td[5] = 16'hFFFF; tbr[5] = 1'b1;
    ta[6] = 16'h7FFF; tb_[6] = 16'hFFFF; td[6] = 16'h8000; tbr[6] = 1'b1;
    ta[7] = 16'h1234; tb_[7] = 16'h0234; td[7] = 16'h1000; tbr[7] = 1'b0;
`ifdef MY_SERIAL_SUBTRACTOR_FLAGS_EN
    tf[0] = 3'b000; tf[1] = 3'b010; tf[2] = 3'b001; tf[3] = 3'b100;
    tf[4] = 3'b100; tf[5] = 3'b010; tf[6] = 3'b011; tf[7] = 3'b000;
`endif
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb_[i], lat);
      vectors++; if (lat != W) begin miscompares++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, W); end
      vectors++; if (diff !== td[i]) begin miscompares++; $display("FAIL vec%0d_diff got=%h exp=%h", i, diff, td[i]); end
      vectors++; if (borrow !== tbr[i]) begin miscompares++; $display("FAIL vec%0d_borrow got=%b exp=%b", i, borrow, tbr[i]); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL vec%0d_in_ready_done got=%b exp=0", i, in_ready); end
`ifdef MY_SERIAL_SUBTRACTOR_FLAGS_EN
      vectors++; if ({zero, neg, ovf} !== tf[i]) begin miscompares++; $display("FAIL vec%0d_flags got=%b exp=%b", i, {zero, neg, ovf}, tf[i]); end
`endif
      $display("op: a=%h b=%h -> diff=%h borrow=%b latency=%0d", ta[i], tb_[i], diff, borrow, lat);
      drain();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL vec%0d_return_idle got=%b exp=1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'h000A, 16'h0004, lat);
    vectors++; if (lat != W) begin miscompares++; $display("FAIL bp_latency got=%0d exp=%0d", lat, W); end
    @(negedge clk);
    a = 16'h0001;
    b = 16'h0001;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      vectors++; if (diff !== 16'h0006) begin miscompares++; $display("FAIL bp_diff_hold%0d got=%h exp=0006", i, diff); end
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hs_hold%0d got=%b%b exp=10", i, out_valid, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_no_accept_in_done got=%b%b exp=10", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_accept_in_idle got=%b exp=0", in_ready); end
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    vectors++; if (lat != W) begin miscompares++; $display("FAIL bp_second_latency got=%0d exp=%0d", lat, W); end
    vectors++; if (diff !== 16'h0000) begin miscompares++; $display("FAIL bp_second_diff got=%h exp=0000", diff); end
    $display("backpressure: held 10 cycles, second op diff=%h latency=%0d", diff, lat);
    drain();
  endtask

  task automatic test_reset_midrun();
    int lat;
    @(negedge clk);
    a = 16'h00FF;
    b = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrun_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrun_out_valid got=%b exp=0", out_valid); end
    vectors++; if (diff !== 16'h0000) begin miscompares++; $display("FAIL midrun_diff got=%h exp=0000", diff); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrun_stays_idle got=%b exp=1", in_ready); end
    run_op(16'h0009, 16'h0004, lat);
    vectors++; if (lat != W) begin miscompares++; $display("FAIL midrun_after_latency got=%0d exp=%0d", lat, W); end
    vectors++; if (diff !== 16'h0005) begin miscompares++; $display("FAIL midrun_after_diff got=%h exp=0005", diff); end
    vectors++; if (borrow !== 1'b0) begin miscompares++; $display("FAIL midrun_after_borrow got=%b exp=0", borrow); end
    $display("reset mid-run: then a=0009 b=0004 -> diff=%h borrow=%b", diff, borrow);
    drain();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
